// File: rtl/if_stage.sv
// Dual-issue instruction fetch stage: refills a fetch window from memory and
// issues consecutive word pairs to decode, with stall hold and branch redirect.
module if_stage #(
    parameter int WIN_WORDS = 256,
    parameter int PC_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [0:31]     instr [0:WIN_WORDS-1],
    output logic [PC_W-1:0] pc,
    output logic            read_enable,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [31:0]     instr_even,
    output logic [31:0]     instr_odd,
    output logic [PC_W-1:0] pc_out,
    output logic            valid
);

    localparam int OFF_W = $clog2(WIN_WORDS / 2);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(WIN_WORDS / 2 - 1);

    typedef enum logic {REQ, ISSUE} state_t;

    state_t           state, state_n;
    logic [OFF_W-1:0] off, off_n;
    logic [PC_W-1:0]  pc_n, pc_out_n;
    logic [31:0]      even_n, odd_n;
    logic             valid_n;
    logic [OFF_W:0]   idx_even, idx_odd;

    assign idx_even = {off, 1'b0};
    assign idx_odd  = {off, 1'b1};

    // State is REQ throughout reset, so the request is masked until release.
    assign read_enable = (state == REQ) && !reset;

    always_comb begin
        state_n  = state;
        off_n    = off;
        pc_n     = pc;
        pc_out_n = pc_out;
        even_n   = instr_even;
        odd_n    = instr_odd;
        valid_n  = valid;
        if (branch_taken) begin
            state_n = REQ;
            pc_n    = branch_target;
            off_n   = '0;
            valid_n = 1'b0;
        end else if (state == REQ) begin
            state_n = ISSUE;
            off_n   = '0;
            valid_n = 1'b0;
        end else if (!stall) begin
            even_n   = instr[idx_even];
            odd_n    = instr[idx_odd];
            pc_out_n = pc + PC_W'(idx_even);
            valid_n  = 1'b1;
            off_n    = off + 1'b1;
            // Window exhausted: refetch from the same base (wraps mod 2^PC_W).
            if (off == OFF_LAST)
                state_n = REQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= REQ;
            off        <= '0;
            pc         <= '0;
            pc_out     <= '0;
            instr_even <= '0;
            instr_odd  <= '0;
            valid      <= 1'b0;
        end else begin
            state      <= state_n;
            off        <= off_n;
            pc         <= pc_n;
            pc_out     <= pc_out_n;
            instr_even <= even_n;
            instr_odd  <= odd_n;
            valid      <= valid_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, exhaustion and reset sequences,
// then random stall/branch traffic against a fetch-queue reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:31] instr [0:255];
    logic [7:0]  pc;
    logic        read_enable;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [31:0] instr_even, instr_odd;
    logic [7:0]  pc_out;
    logic        valid;

    if_stage dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .read_enable(read_enable),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_even(instr_even), .instr_odd(instr_odd), .pc_out(pc_out), .valid(valid)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    initial for (int n = 0; n < 256; n++) mem[n] = n;

    // Memory: window loads from pc on the edge that samples read_enable.
    always @(posedge clk)
        if (read_enable)
            for (int k = 0; k < 256; k++) instr[k] <= mem[(pc + k) & 8'hff];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic       st;
        logic       br;
        logic [7:0] tgt;
        logic       re;
        logic [7:0] pc;
        logic       vld;
        logic [7:0] pco;
        logic [31:0] ev;
        logic [31:0] od;
    } vec_t;

    vec_t vt [14];

    // Reference model: a pending-fetch flag, the window base and pairs issued.
    bit   m_fetch;
    logic [7:0] m_base;
    int   m_k;
    logic m_valid;
    logic [31:0] m_even, m_odd;
    logic [7:0] m_pco;

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_re", read_enable, 0);
        check("rst_valid", valid, 0);
        check("rst_even", instr_even, 0);
        check("rst_odd", instr_odd, 0);
        check("rst_pc", pc, 0);
        check("rst_pc_out", pc_out, 0);
        reset = 1'b0;
        #1;
        check("rel_re", read_enable, 1);
        check("rel_pc", pc, 0);
        check("rel_valid", valid, 0);
    endtask

    initial begin
        stall = 0; branch_taken = 0; branch_target = 0;
        vt[0]  = '{0,0,8'h00, 0,8'h00, 0,8'h00, 0,0};
        vt[1]  = '{0,0,8'h00, 0,8'h00, 1,8'h00, 0,1};
        vt[2]  = '{0,0,8'h00, 0,8'h00, 1,8'h02, 2,3};
        vt[3]  = '{1,0,8'h00, 0,8'h00, 1,8'h02, 2,3};
        vt[4]  = '{1,0,8'h00, 0,8'h00, 1,8'h02, 2,3};
        vt[5]  = '{1,0,8'h00, 0,8'h00, 1,8'h02, 2,3};
        vt[6]  = '{0,0,8'h00, 0,8'h00, 1,8'h04, 4,5};
        vt[7]  = '{1,1,8'h40, 1,8'h40, 0,8'h04, 4,5};
        vt[8]  = '{0,0,8'h00, 0,8'h00, 0,8'h04, 4,5};
        vt[9]  = '{0,0,8'h00, 0,8'h00, 1,8'h40, 32'h40,32'h41};
        vt[10] = '{0,1,8'h81, 1,8'h81, 0,8'h40, 32'h40,32'h41};
        vt[11] = '{0,1,8'h10, 1,8'h10, 0,8'h40, 32'h40,32'h41};
        vt[12] = '{0,0,8'h00, 0,8'h00, 0,8'h40, 32'h40,32'h41};
        vt[13] = '{0,0,8'h00, 0,8'h00, 1,8'h10, 32'h10,32'h11};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            stall = vt[i].st; branch_taken = vt[i].br; branch_target = vt[i].tgt;
            @(negedge clk);
            check($sformatf("v%0d_re", i), read_enable, vt[i].re);
            if (vt[i].re) check($sformatf("v%0d_pc", i), pc, vt[i].pc);
            check($sformatf("v%0d_valid", i), valid, vt[i].vld);
            check($sformatf("v%0d_pc_out", i), pc_out, vt[i].pco);
            check($sformatf("v%0d_even", i), instr_even, vt[i].ev);
            check($sformatf("v%0d_odd", i), instr_odd, vt[i].od);
        end
        stall = 0; branch_taken = 0;

        // Exhaustion from an odd base that wraps past 0xFF.
        branch_taken = 1; branch_target = 8'hF1;
        @(negedge clk);
        branch_taken = 0;
        @(negedge clk);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            if (k % 16 == 0 || k == 127) begin
                check("exh_pc_out", pc_out, (8'hF1 + 2 * k) & 8'hff);
                check("exh_even", instr_even, (8'hF1 + 2 * k) & 8'hff);
                check("exh_odd", instr_odd, (8'hF2 + 2 * k) & 8'hff);
            end
            if (k < 127) check("exh_no_re", read_enable, 0);
        end
        check("exh_re", read_enable, 1);
        check("exh_pc", pc, 8'hF1);
        check("exh_valid", valid, 1);
        @(negedge clk);
        check("exh_refill_valid", valid, 0);
        check("exh_refill_re", read_enable, 0);

        // Asynchronous reset mid-issue: outputs clear before any edge.
        @(negedge clk);
        @(posedge clk);
        #2;
        check("mid_pre_valid", valid, 1);
        reset = 1'b1;
        #1;
        check("mid_valid", valid, 0);
        check("mid_even", instr_even, 0);
        check("mid_pc_out", pc_out, 0);
        check("mid_re", read_enable, 0);
        do_reset();
        @(negedge clk);
        @(negedge clk);
        check("mid_restart_valid", valid, 1);
        check("mid_restart_pc_out", pc_out, 0);
        check("mid_restart_odd", instr_odd, 1);

        // Random traffic; restart the model from a fresh reset.
        do_reset();
        m_fetch = 1; m_base = 0; m_k = 0; m_valid = 0;
        m_even = 0; m_odd = 0; m_pco = 0;
        for (int c = 0; c < 1500; c++) begin
            stall         = ($urandom_range(0, 9) < 3);
            branch_taken  = ($urandom_range(0, 39) == 0);
            branch_target = 8'($urandom);
            @(posedge clk);
            if (branch_taken) begin
                m_base = branch_target; m_fetch = 1; m_valid = 0;
            end else if (m_fetch) begin
                m_fetch = 0; m_k = 0; m_valid = 0;
            end else if (!stall) begin
                m_pco   = 8'((m_base + 2 * m_k) & 255);
                m_even  = mem[m_pco];
                m_odd   = mem[(m_pco + 1) & 255];
                m_valid = 1;
                m_k++;
                if (m_k == 128) m_fetch = 1;
            end
            @(negedge clk);
            check("rnd_re", read_enable, m_fetch);
            if (m_fetch) check("rnd_pc", pc, m_base);
            check("rnd_valid", valid, m_valid);
            if (m_valid) begin
                check("rnd_pc_out", pc_out, m_pco);
                check("rnd_even", instr_even, m_even);
                check("rnd_odd", instr_odd, m_odd);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: WIN_WORDS, 256, number of 32-bit instruction words in the fetch window supplied on instr.
REQ-002 Parameter: PC_W, 8, width of every address and PC port.
REQ-003 Port: clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: instr  input  256 x 32 (unpacked [0:255], each word [0:31])  fetch window; instr[k] is the word at address pc+k, valid from the cycle after read_enable=1 until the next read_enable=1.
REQ-006 Port: pc  output  8  window base address presented with a refill request.
REQ-007 Port: read_enable  output  1  refill request; memory loads instr from pc on the same rising edge that samples read_enable=1.
REQ-008 Port: stall  input  1  back-pressure from decode; 1 = hold issue.
REQ-009 Port: branch_taken  input  1  redirect request, sampled each rising edge.
REQ-010 Port: branch_target  input  8  redirect address.
REQ-011 Port: instr_even  output  32  first issued word of the pair.
REQ-012 Port: instr_odd  output  32  second issued word of the pair.
REQ-013 Port: pc_out  output  8  address of instr_even.
REQ-014 Port: valid  output  1  issued pair is valid this cycle.
REQ-015 The first five ports SHALL appear in the order clk, reset, instr, pc, read_enable; the others follow in listed order.

Function
REQ-016 The block SHALL implement the states REQ and ISSUE, plus a 7-bit pair offset off (word offset = 2*off).
REQ-017 In REQ: read_enable=1 for exactly one cycle, and pc holds the window base; the next state SHALL be ISSUE with off=0.
REQ-018 In ISSUE with stall=0: the block SHALL register instr_even=instr[2*off], instr_odd=instr[2*off+1], pc_out=pc+2*off (mod 256), valid=1, then increment off.
REQ-019 In ISSUE with stall=1: the block SHALL hold instr_even, instr_odd, pc_out, valid and off unchanged.
REQ-020 Exhaustion: after the pair at off=127 is issued, the next state SHALL be REQ with pc=pc+256 mod 256 (unchanged base).
REQ-021 Redirect: branch_taken=1 at any edge outside reset SHALL set pc=branch_target, next state REQ, valid=0, regardless of stall or state.
REQ-022 Priority at an edge: reset > branch_taken > stall > exhaustion > normal issue.
REQ-023 valid SHALL be 0 in every cycle whose preceding edge did not register a new pair, except when holding under stall.
REQ-024 read_enable SHALL never be 1 in two consecutive cycles unless a branch_taken arrives during REQ, in which case REQ repeats with the new pc.
REQ-025 All address arithmetic SHALL be 8-bit modulo 256; an odd branch_target is legal and issues pairs starting at that odd address.
REQ-026 Outputs SHALL be driven from registers only; no combinational path from instr, stall or branch inputs to any output.

Reset
REQ-027 While reset=1: state=REQ, pc=0, off=0, read_enable=0, valid=0, instr_even=0, instr_odd=0, pc_out=0.
REQ-028 In the first cycle after reset deasserts, read_enable=1 with pc=0.
REQ-029 Reset asserted mid-operation SHALL immediately force the REQ-027 values and discard the window in progress.

Verification
REQ-030 Reset for 2 cycles, then release -> next cycle read_enable=1 and pc=0; all outputs 0 during reset.
REQ-031 Memory word n = n after refill -> pairs (0,1),(2,3),(4,5) with pc_out 0,2,4 and valid=1 on consecutive cycles.
REQ-032 stall=1 for 3 cycles during issue -> outputs frozen for 3 cycles; issue resumes at the next pair.
REQ-033 branch_taken=1 with branch_target=0x40 -> valid=0, read_enable=1 with pc=0x40, then pair (mem[0x40],mem[0x41]) with pc_out=0x40.
REQ-034 128 pairs issued with no stall -> read_enable=1 with pc equal to the old base.
REQ-035 reset pulse mid-issue -> outputs zero immediately, then the REQ-028 restart sequence.
